pause_ctrl: RTL and testbench
=============================

Name: pause_ctrl

Overview:
- Clocked, parametrised successor to the washer's pause/resume latch.
- Owns the cycle run state: OFF, RUN, PAUSED, DONE.
- Debounces the raw pause button, honours power-off and finish with fixed priority, and auto-terminates a cycle left paused too long.
- Sits between the panel buttons and the wash/rinse/spin sequencer. The sequencer freezes its timers while `running` is low.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable sampled cycles needed to accept a new button level (>=1).
- PAUSE_TIMEOUT, 20, cycles spent in PAUSED before the cycle is forced to DONE (>=1).
- CNT_W, 16, width of the debounce and timeout counters. Must hold max(DEBOUNCE_CYCLES, PAUSE_TIMEOUT).
- BLINK_HALF, 8, half-period in cycles of pause_led blinking. Used only with PAUSE_BLINK_EN.

Ports:
- clk  in  1  system clock, all state on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- power_on  in  1  power switch level, already synchronous.
- pause_btn  in  1  raw, asynchronous, bouncing pause button.
- finish  in  1  one-cycle pulse from the sequencer: program complete.
- running  out  1  high only in RUN.
- pause_led  out  1  high in PAUSED (blinks with PAUSE_BLINK_EN).
- done  out  1  high in DONE.
- timeout_pulse  out  1  one-cycle pulse when PAUSED expires.
- state  out  2  encoded state: OFF=0, RUN=1, PAUSED=2, DONE=3.

Behaviour:
- Reset (async assert, sync release):
  - state=OFF; all outputs 0.
  - Sync flops, debounced level, counters and blink phase all 0.
- Button path:
  - Raw input goes through a 2-flop synchroniser.
  - The debounce counter increments while the synchronised value differs from the debounced level. It clears otherwise.
  - At DEBOUNCE_CYCLES the debounced level flips and the counter clears.
  - press_evt is a 1-cycle pulse on a debounced 0->1 transition. Release produces no event.
  - Total latency from a clean raw rise to the state change is DEBOUNCE_CYCLES+3 edges.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
- Transitions, evaluated each edge in this priority order:
  1. power_on==0 -> OFF, from any state.
  2. OFF and power_on==1 -> RUN next edge.
  3. finish==1 in RUN or PAUSED -> DONE. Finish wins over a simultaneous press_evt.
  4. RUN with press_evt -> PAUSED; timeout counter cleared.
  5. PAUSED with press_evt -> RUN.
  6. PAUSED otherwise: timeout counter +1. When it reaches PAUSE_TIMEOUT-1 -> DONE, and timeout_pulse=1 on that same edge.
  7. DONE: holds until power_on drops. press_evt and finish are ignored.
- Timeout counter:
  - Counts only in PAUSED.
  - Clears on entry to PAUSED and in every other state. Re-pausing restarts the full timeout.
  - Never wraps; saturation is not reachable.
- Outputs are registered and decoded from the next state, so they change on the same edge as state.
- A press_evt arriving in OFF or DONE is discarded, not queued.
- Power drop mid-debounce: the debounce logic keeps running, so a later press is still seen once.

Optional Feature:
- Macro: PAUSE_BLINK_EN.
- Defined:
  - In PAUSED, pause_led toggles every BLINK_HALF cycles. The first half-period is high, starting on the PAUSED entry edge.
  - The blink counter clears whenever state is not PAUSED.
- Undefined: pause_led is a steady 1 in PAUSED. No blink counter is synthesised.

Decomposition:
- Shared package pause_ctrl_pkg holds:
  - typedef run_state_t (2-bit enum OFF/RUN/PAUSED/DONE).
  - Default localparams for DEBOUNCE_CYCLES and PAUSE_TIMEOUT.
- One sub-module: btn_debounce, parametrised by DEBOUNCE_CYCLES and CNT_W.
  - Contains the synchroniser, counter and edge detector.
  - Outputs the debounced level and press_evt.
  - Reused for the start and program buttons.

Test Plan:
- Reset, then power_on=1 -> state=RUN and running=1 on the 1st edge after reset release; all other outputs 0.
- RUN, pause_btn clean high for 10 cycles -> state=PAUSED exactly 7 edges after the rise; a second press -> RUN after 7 edges.
- Pause_btn pulses of 3 cycles high/1 low repeated -> no state change; then hold high 10 cycles -> exactly one toggle.
- PAUSED with no press -> DONE plus a 1-cycle timeout_pulse 20 edges after entry; a press in DONE -> no change.
- finish pulse on the same edge as press_evt in RUN -> DONE, not PAUSED; then power_on=0 -> OFF next edge.
- With PAUSE_BLINK_EN, PAUSED -> pause_led high 8 cycles, low 8, high 8; rst asserted mid-PAUSED -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pause_ctrl_pkg.sv
// Shared types and default parameters for the washer pause/resume controller
// and its button debouncer.
package pause_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } run_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PAUSE_TIMEOUT   = 20;
  localparam int DEF_CNT_W           = 16;

endpackage

// File: rtl/pause_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge
// detector. Shared by the pause, start and program buttons.
module btn_debounce
  import pause_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press_evt
);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic             differs;
  logic             accept;

  assign differs = (sync_b != level);
  assign accept  = differs && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a    <= 1'b0;
      sync_b    <= 1'b0;
      cnt       <= '0;
      level     <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let sync_b take the old sync_a, forming
      // a true two-stage synchroniser regardless of statement order.
      sync_a    <= raw;
      sync_b    <= sync_a;
      press_evt <= accept && !level;
      if (accept) begin
        level <= ~level;
        cnt   <= '0;
      end else if (differs) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pause_ctrl.sv
// Washer run-state controller: OFF/RUN/PAUSED/DONE with debounced pause button,
// power/finish priority and paused timeout. Optional macro: PAUSE_BLINK_EN.
module pause_ctrl
  import pause_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PAUSE_TIMEOUT   = DEF_PAUSE_TIMEOUT,
  parameter int CNT_W           = DEF_CNT_W
`ifdef PAUSE_BLINK_EN
  ,
  parameter int BLINK_HALF      = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_on,
  input  logic       pause_btn,
  input  logic       finish,
  output logic       running,
  output logic       pause_led,
  output logic       done,
  output logic       timeout_pulse,
  output logic [1:0] state
);

  run_state_t       cur;
  run_state_t       nxt;
  logic             press_evt;
  logic             btn_level;
  logic             expire;
  logic [CNT_W-1:0] tmo_cnt;
  logic             running_nxt;
  logic             led_nxt;
  logic             done_nxt;
  logic             tmo_nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn (
    .clk      (clk),
    .rst      (rst),
    .raw      (pause_btn),
    .level    (btn_level),
    .press_evt(press_evt)
  );

  assign state = cur;

  // State register; outputs are registered from the next-state decode so they
  // move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur           <= ST_OFF;
      running       <= 1'b0;
      pause_led     <= 1'b0;
      done          <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      cur           <= nxt;
      running       <= running_nxt;
      pause_led     <= led_nxt;
      done          <= done_nxt;
      timeout_pulse <= tmo_nxt;
    end
  end

  // Paused-time counter; restarts on every entry to PAUSED and leaves before T.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (cur == ST_PAUSED && nxt == ST_PAUSED) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch forms.
    nxt    = cur;
    expire = 1'b0;
    if (!power_on) begin
      nxt = ST_OFF;
    end else begin
      case (cur)
        ST_OFF: nxt = ST_RUN;
        ST_RUN: begin
          if (finish)         nxt = ST_DONE;
          else if (press_evt) nxt = ST_PAUSED;
        end
        ST_PAUSED: begin
          if (finish)         nxt = ST_DONE;
          else if (press_evt) nxt = ST_RUN;
          else if (tmo_cnt == CNT_W'(PAUSE_TIMEOUT - 1)) begin
            nxt    = ST_DONE;
            expire = 1'b1;
          end
        end
        ST_DONE: nxt = ST_DONE;
        default: nxt = ST_OFF;
      endcase
    end
  end

`ifdef PAUSE_BLINK_EN
  logic [CNT_W-1:0] blink_cnt;
  logic             blink_wrap;

  assign blink_wrap = (blink_cnt == CNT_W'(BLINK_HALF - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
    end else if (cur == ST_PAUSED && nxt == ST_PAUSED && !blink_wrap) begin
      blink_cnt <= blink_cnt + 1'b1;
    end else begin
      blink_cnt <= '0;
    end
  end
`endif

  always_comb begin
    running_nxt = (nxt == ST_RUN);
    done_nxt    = (nxt == ST_DONE);
    tmo_nxt     = expire;
`ifdef PAUSE_BLINK_EN
    // The registered pause_led doubles as the blink phase; entry starts high.
    led_nxt = 1'b0;
    if (nxt == ST_PAUSED) begin
      if (cur != ST_PAUSED) led_nxt = 1'b1;
      else                  led_nxt = blink_wrap ? ~pause_led : pause_led;
    end
`else
    led_nxt = (nxt == ST_PAUSED);
`endif
  end

endmodule

// File: tb/tb_pause_ctrl.sv
// Self-checking bench for pause_ctrl: directed scenarios plus randomized
// stimulus compared every cycle against an edge-indexed behavioural model.
module tb_pause_ctrl;

  localparam int D  = 4;
  localparam int T  = 20;
  localparam int BH = 8;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       power_on  = 1'b0;
  logic       pause_btn = 1'b0;
  logic       finish    = 1'b0;
  logic       running;
  logic       pause_led;
  logic       done;
  logic       timeout_pulse;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  pause_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .power_on     (power_on),
    .pause_btn    (pause_btn),
    .finish       (finish),
    .running      (running),
    .pause_led    (pause_led),
    .done         (done),
    .timeout_pulse(timeout_pulse),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw samples delayed two edges, a level is accepted after
  // D consecutive differing samples, and the run state follows the priority rules.
  int  hist[$];
  int  m_deb, m_run, edge_n, entry;
  bit  m_press;
  int  e_state;
  bit  e_run, e_led, e_done, e_tmo;

  task automatic model_reset();
    hist.delete();
    hist.push_back(0);
    hist.push_back(0);
    m_deb   = 0;
    m_run   = 0;
    m_press = 1'b0;
    edge_n  = 0;
    entry   = 0;
    e_state = 0;
    e_run   = 1'b0;
    e_led   = 1'b0;
    e_done  = 1'b0;
    e_tmo   = 1'b0;
  endtask

  task automatic model_step();
    int seen;
    bit press_now;
    press_now = m_press;
    m_press   = 1'b0;
    seen      = hist.pop_front();
    hist.push_back(int'(pause_btn));
    if (seen != m_deb) begin
      m_run++;
      if (m_run == D) begin
        m_deb   = seen;
        m_run   = 0;
        m_press = (seen == 1);
      end
    end else begin
      m_run = 0;
    end
    edge_n++;
    e_tmo = 1'b0;
    if (!power_on) e_state = 0;
    else begin
      case (e_state)
        0: e_state = 1;
        1: begin
          if (finish) e_state = 3;
          else if (press_now) begin
            e_state = 2;
            entry   = edge_n;
          end
        end
        2: begin
          if (finish) e_state = 3;
          else if (press_now) e_state = 1;
          else if (edge_n - entry == T) begin
            e_state = 3;
            e_tmo   = 1'b1;
          end
        end
        default: e_state = 3;
      endcase
    end
    e_run  = (e_state == 1);
    e_done = (e_state == 3);
`ifdef PAUSE_BLINK_EN
    e_led = (e_state == 2) && ((((edge_n - entry) / BH) % 2) == 0);
`else
    e_led = (e_state == 2);
`endif
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("state", state, e_state);
      check("running", running, e_run);
      check("pause_led", pause_led, e_led);
      check("done", done, e_done);
      check("timeout_pulse", timeout_pulse, e_tmo);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (state == st) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int to;
    int hold_left;

    cycles(3);
    check("rst_state", state, 0);
    check("rst_running", running, 0);
    check("rst_led", pause_led, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout_pulse, 0);

    rst = 1'b0;
    power_on = 1'b1;
    cycles(1);
    check("power_up_state", state, 1);
    check("power_up_running", running, 1);
    check("power_up_led", pause_led, 0);
    check("power_up_done", done, 0);
    cycles(2);

    // Clean press and resume
    pause_btn = 1'b1;
    wait_state(2, 30, n);
    check("pause_latency", n, 7);
    cycles(3);
    pause_btn = 1'b0;
    cycles(7);
    pause_btn = 1'b1;
    wait_state(1, 30, n);
    check("resume_latency", n, 7);
    cycles(3);
    pause_btn = 1'b0;
    cycles(8);

    // Short glitches are rejected, then one long hold toggles once
    for (int k = 0; k < 5; k++) begin
      pause_btn = 1'b1;
      cycles(3);
      pause_btn = 1'b0;
      cycles(1);
    end
    check("glitch_no_change", state, 1);
    pause_btn = 1'b1;
    wait_state(2, 30, n);
    check("hold_after_glitch", n, 7);

    // Timeout from PAUSED
    to = -1;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (done) begin
        to = j;
        break;
      end
      if (j == 3) pause_btn = 1'b0;
    end
    check("timeout_edges", to, 20);
    check("timeout_pulse_high", timeout_pulse, 1);
    cycles(1);
    check("timeout_pulse_low", timeout_pulse, 0);
    check("done_holds", done, 1);

    pause_btn = 1'b1;
    cycles(10);
    pause_btn = 1'b0;
    cycles(8);
    check("done_ignores_press", state, 3);

    // Finish beats a simultaneous press
    power_on = 1'b0;
    cycles(1);
    check("power_off", state, 0);
    power_on = 1'b1;
    cycles(2);
    pause_btn = 1'b1;
    cycles(6);
    finish = 1'b1;
    cycles(1);
    finish = 1'b0;
    check("finish_beats_press", state, 3);
    power_on = 1'b0;
    cycles(1);
    check("off_after_done", state, 0);
    power_on  = 1'b1;
    pause_btn = 1'b0;
    cycles(10);

    // Randomized traffic
    hold_left = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_left == 0) begin
        pause_btn = 1'($urandom_range(0, 1));
        hold_left = int'($urandom_range(1, 12));
      end
      hold_left--;
      finish = ($urandom_range(0, 29) == 0);
      if (!power_on)  power_on = ($urandom_range(0, 3) == 0);
      else if (done)  power_on = ($urandom_range(0, 7) != 0);
      else            power_on = ($urandom_range(0, 199) != 0);
      cycles(1);
    end
    finish = 1'b0;

`ifdef PAUSE_BLINK_EN
    rst = 1'b1;
    cycles(2);
    rst       = 1'b0;
    power_on  = 1'b1;
    pause_btn = 1'b0;
    cycles(12);
    pause_btn = 1'b1;
    wait_state(2, 30, n);
    check("blink_entry", n, 7);
    check("blink_0", pause_led, 1);
    for (int j = 1; j <= 17; j++) begin
      cycles(1);
      if (j == 3) pause_btn = 1'b0;
      check("blink_phase", pause_led, ((j < 8) || (j >= 16)) ? 1 : 0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_led", pause_led, 0);
    check("async_rst_running", running, 0);
    check("async_rst_done", done, 0);
    check("async_rst_timeout", timeout_pulse, 0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
